spm_prog_loader: RTL and testbench

SPM_PROG_LOADER -- requirements
Module: spm_prog_loader

---
 rtl/spm_prog_loader_pkg.sv | 38 +++
 rtl/spm_prog_loader_uart_rx.sv | 128 ++++++++++++
 rtl/spm_prog_loader.sv | 167 ++++++++++++++++
 tb/tb_spm_prog_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spm_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_prog_loader_pkg
// Description : Shared definitions for the scratch-pad program loader.
//               Holds the loader FSM state encoding, the receiver state
//               encoding, the default frame-start marker and the byte-count
//               width. The width is 9 bits because LEN=0 means 256 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_prog_loader_pkg;

    localparam logic [7:0]  c_sync_byte_default = 8'hA5;
    localparam int unsigned c_count_w           = 9;

    // Loader frame FSM
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } load_state_t;

    // UART receiver FSM
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A LEN byte of zero encodes a full 256-byte payload.
    function automatic logic [c_count_w-1:0] len_to_count(input logic [7:0] len);
        return (len == 8'h00) ? 9'd256 : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spm_prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : spm_uart_rx
// Description : 8N1 UART receiver, LSB first, idle high.
//               Ports:
//                 clk         - clock
//                 rst         - asynchronous reset, active-low
//                 i_rx        - raw serial input from the pad
//                 o_rx_valid  - one-cycle strobe, o_rx_data holds a good byte
//                 o_rx_data   - received byte
//                 o_frame_err - one-cycle strobe, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module spm_uart_rx
    import spm_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_frame_err
);

    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_half_last = 16'(CLKS_PER_BIT / 2 - 1);

    logic        r_rx_meta;
    logic        r_rx_sync;
    rx_state_t   r_state,   w_state_nxt;
    logic [15:0] r_cnt,     w_cnt_nxt;
    logic [2:0]  r_bit_idx, w_bit_idx_nxt;
    logic [7:0]  r_shift,   w_shift_nxt;
    logic        r_valid,   w_valid_nxt;
    logic        r_err,     w_err_nxt;

    // Two-flop synchronizer; resets to the idle-high line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_sync) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Half a bit after the falling edge: a real start bit is
                // still low, anything else was a glitch.
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (r_rx_sync) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt   = RX_DATA;
                        w_bit_idx_nxt = '0;
                    end
                end
            end
            RX_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RX_IDLE;
                    if (r_rx_sync) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign o_rx_valid  = r_valid;
    assign o_rx_data   = r_shift;
    assign o_frame_err = r_err;

endmodule
`default_nettype wire

// File: rtl/spm_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : spm_prog_loader
// Description : Receives a program image over UART and writes it into the
//               processor scratch-pad memory, holding the processor in reset
//               until a frame with a good checksum has been loaded.
//               Frame: SYNC_BYTE, START_ADDR, LEN, LEN data bytes, CSUM.
//               Ports:
//                 clk         - clock
//                 rst         - asynchronous reset, active-low
//                 rx_i        - UART serial input (8N1, idle high)
//                 ext_write   - one-cycle memory write strobe
//                 address_bus - write address, held between strobes
//                 data_bus    - write data, held between strobes
//                 cpu_rst     - processor reset hold, active-high
//                 busy        - frame in progress
//                 load_done   - last frame loaded with good checksum (sticky)
//                 load_err    - last frame failed checksum/framing (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module spm_prog_loader
    import spm_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = c_sync_byte_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       ext_write,
    output logic [7:0] address_bus,
    output logic [7:0] data_bus,
    output logic       cpu_rst,
    output logic       busy,
    output logic       load_done,
    output logic       load_err
);

    logic       w_rx_valid;
    logic [7:0] w_rx_data;
    logic       w_frame_err;

    load_state_t          r_state,     w_state_nxt;
    logic [7:0]           r_addr,      w_addr_nxt;
    logic [c_count_w-1:0] r_remaining, w_remaining_nxt;
    logic [7:0]           r_csum,      w_csum_nxt;
    logic                 r_ext_write, w_ext_write_nxt;
    logic [7:0]           r_addr_bus,  w_addr_bus_nxt;
    logic [7:0]           r_data_bus,  w_data_bus_nxt;
    logic                 r_cpu_rst,   w_cpu_rst_nxt;
    logic                 r_done,      w_done_nxt;
    logic                 r_err,       w_err_nxt;

    spm_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (rx_i),
        .o_rx_valid  (w_rx_valid),
        .o_rx_data   (w_rx_data),
        .o_frame_err (w_frame_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_csum      <= '0;
            r_ext_write <= 1'b0;
            r_addr_bus  <= '0;
            r_data_bus  <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_csum      <= w_csum_nxt;
            r_ext_write <= w_ext_write_nxt;
            r_addr_bus  <= w_addr_bus_nxt;
            r_data_bus  <= w_data_bus_nxt;
            r_cpu_rst   <= w_cpu_rst_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_csum_nxt      = r_csum;
        w_ext_write_nxt = 1'b0;
        w_addr_bus_nxt  = r_addr_bus;
        w_data_bus_nxt  = r_data_bus;
        w_cpu_rst_nxt   = r_cpu_rst;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;

        if (w_frame_err) begin
            // A broken byte mid-frame aborts the load; in IDLE the line may
            // just be noisy before a real frame, so it is ignored there.
            if (r_state != IDLE) begin
                w_state_nxt   = IDLE;
                w_err_nxt     = 1'b1;
                w_cpu_rst_nxt = 1'b1;
            end
        end else if (w_rx_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_rx_data == SYNC_BYTE) begin
                        w_state_nxt   = ADDR;
                        w_cpu_rst_nxt = 1'b1;
                        w_done_nxt    = 1'b0;
                        w_err_nxt     = 1'b0;
                        w_csum_nxt    = '0;
                    end
                end
                ADDR: begin
                    w_addr_nxt  = w_rx_data;
                    w_state_nxt = LEN;
                end
                LEN: begin
                    w_remaining_nxt = len_to_count(w_rx_data);
                    w_state_nxt     = DATA;
                end
                DATA: begin
                    w_ext_write_nxt = 1'b1;
                    w_addr_bus_nxt  = r_addr;
                    w_data_bus_nxt  = w_rx_data;
                    w_addr_nxt      = r_addr + 8'd1;
                    w_csum_nxt      = r_csum + w_rx_data;
                    w_remaining_nxt = r_remaining - 9'd1;
                    if (r_remaining == 9'd1) begin
                        w_state_nxt = CSUM;
                    end
                end
                CSUM: begin
                    w_state_nxt = IDLE;
                    if (w_rx_data == r_csum) begin
                        w_done_nxt    = 1'b1;
                        w_cpu_rst_nxt = 1'b0;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_cpu_rst_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign ext_write   = r_ext_write;
    assign address_bus = r_addr_bus;
    assign data_bus    = r_data_bus;
    assign cpu_rst     = r_cpu_rst;
    assign busy        = (r_state != IDLE);
    assign load_done   = r_done;
    assign load_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spm_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spm_prog_loader
// Description : Directed self-checking bench for spm_prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_prog_loader;

    localparam int unsigned c_cpb = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ext_write;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       cpu_rst;
    logic       busy;
    logic       load_done;
    logic       load_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    spm_prog_loader #(
        .CLKS_PER_BIT (c_cpb),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .ext_write   (ext_write),
        .address_bus (address_bus),
        .data_bus    (data_bus),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (ext_write) begin
            wr_addr_q.push_back(address_bus);
            wr_data_q.push_back(data_bus);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (c_cpb) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        wait_bit();
        rx = 1'b1;
        wait_bit();
    endtask

    task automatic send_queue(input int bad_idx);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], (i == bad_idx));
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Compare recorded writes against exp_q starting at start_addr.
    task automatic check_writes(input string tag, input logic [7:0] start_addr);
        logic [7:0] a;
        logic [31:0] obs_a;
        logic [31:0] obs_d;
        check_eq({tag, "_count"}, wr_addr_q.size(), exp_q.size());
        a = start_addr;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs_a = (i < wr_addr_q.size()) ? {24'h0, wr_addr_q[i]} : 32'hDEAD;
            obs_d = (i < wr_data_q.size()) ? {24'h0, wr_data_q[i]} : 32'hDEAD;
            check_eq($sformatf("%s_addr%0d", tag, i), obs_a, {24'h0, a});
            check_eq($sformatf("%s_data%0d", tag, i), obs_d, {24'h0, exp_q[i]});
            a = a + 8'd1;
        end
    endtask

    task automatic check_status(input string tag, input logic e_cpu, input logic e_busy,
                                input logic e_done, input logic e_err);
        check_eq({tag, "_cpu_rst"},   cpu_rst,   e_cpu);
        check_eq({tag, "_busy"},      busy,      e_busy);
        check_eq({tag, "_load_done"}, load_done, e_done);
        check_eq({tag, "_load_err"},  load_err,  e_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ext_write"}, ext_write,   1'b0);
        check_eq({tag, "_addr_bus"},  address_bus, 8'h00);
        check_eq({tag, "_data_bus"},  data_bus,    8'h00);
        check_status(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Good load
        clear_writes();
        send_byte(8'hA5, 1'b0);
        #1;
        check_status("good_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        tx_q  = '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        exp_q = '{8'h11, 8'h22, 8'h33};
        send_queue(-1);
        check_writes("good", 8'h10);
        check_status("good_end", 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("good_hold_addr", address_bus, 8'h12);
        check_eq("good_hold_data", data_bus,    8'h33);

        // Bad checksum; sync must clear the sticky load_done first
        clear_writes();
        send_byte(8'hA5, 1'b0);
        #1;
        check_status("bad_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        tx_q  = '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        exp_q = '{8'h11, 8'h22, 8'h33};
        send_queue(-1);
        check_writes("bad", 8'h10);
        check_status("bad_end", 1'b1, 1'b0, 1'b0, 1'b1);

        // Address wrap and SYNC value as payload
        clear_writes();
        tx_q  = '{8'hA5, 8'hFE, 8'h03, 8'hA5, 8'h01, 8'h02, 8'hA8};
        exp_q = '{8'hA5, 8'h01, 8'h02};
        send_queue(-1);
        check_writes("wrap", 8'hFE);
        check_status("wrap_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Full 256-byte payload (LEN=0), sum of 0..255 is 0x7F80
        clear_writes();
        tx_q  = '{8'hA5, 8'h40, 8'h00};
        exp_q = {};
        for (int i = 0; i < 256; i++) begin
            tx_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        tx_q.push_back(8'h80);
        send_queue(-1);
        check_writes("full", 8'h40);
        check_status("full_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Framing error on second data byte
        clear_writes();
        tx_q  = '{8'hA5, 8'h20, 8'h05, 8'hAA, 8'hBB};
        exp_q = '{8'hAA};
        send_queue(4);
        check_writes("frame", 8'h20);
        check_status("frame_end", 1'b1, 1'b0, 1'b0, 1'b1);

        // Recovery frame, with a short low glitch in an inter-byte gap
        clear_writes();
        tx_q = '{8'hA5, 8'h30, 8'h02};
        send_queue(-1);
        rx = 1'b0;
        repeat (c_cpb / 4) @(posedge clk);
        rx = 1'b1;
        repeat (3 * c_cpb) @(posedge clk);
        tx_q  = '{8'h7E, 8'h01, 8'h7F};
        exp_q = '{8'h7E, 8'h01};
        send_queue(-1);
        check_writes("recover", 8'h30);
        check_status("recover_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset pulsed in the middle of a data byte
        clear_writes();
        tx_q  = '{8'hA5, 8'h60, 8'h04, 8'h01, 8'h02};
        exp_q = '{8'h01, 8'h02};
        send_queue(-1);
        rx = 1'b0;
        repeat (3 * c_cpb) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        rx = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (12 * c_cpb) @(posedge clk);
        tx_q = '{8'h03, 8'h04, 8'h0A};
        send_queue(-1);
        check_writes("midrst", 8'h60);
        check_status("midrst_end", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
